// File: rtl/matrix_row_scanner_pkg.sv
// matrix_scan_pkg
// Shared types and geometry for the 8x8 LED matrix row scanner.
//   scan_state_t : scan FSM state encoding
//   ROWS / ROW_W : matrix rows and row-index width
//   COL_W        : column pattern width
package matrix_scan_pkg;

   localparam int ROWS  = 8;
   localparam int ROW_W = 3;
   localparam int COL_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      DRIVE = 2'd2
   } scan_state_t;

endpackage

// File: rtl/matrix_row_scanner_dbuf.sv
// frame_dbuf
// Double-buffered 8x8 frame store. Writes always land in the back bank,
// reads always come from the front bank; swap flips which bank is front.
// No data is copied on a swap, so the new back bank holds the frame
// before last.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset (clears both banks)
//   wr_en/wr_row/wr_data : write port into the back bank
//   swap            : toggle front select on this edge
//   rd_row/rd_data  : combinational read of the front bank
module frame_dbuf
   import matrix_scan_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [ROW_W-1:0] wr_row,
   input  logic [COL_W-1:0] wr_data,
   input  logic             swap,
   input  logic [ROW_W-1:0] rd_row,
   output logic [COL_W-1:0] rd_data
);

   logic [COL_W-1:0] bank0 [ROWS];
   logic [COL_W-1:0] bank1 [ROWS];
   logic             front_sel;

   // The write uses the pre-swap select, so a write on the swap edge goes
   // into the bank that is becoming back, i.e. shows up next frame.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         front_sel <= 1'b0;
         for (int i = 0; i < ROWS; i++) begin
            bank0[i] <= '0;
            bank1[i] <= '0;
         end
      end else begin
         if (swap)
            front_sel <= ~front_sel;
         if (wr_en) begin
            if (front_sel)
               bank0[wr_row] <= wr_data;
            else
               bank1[wr_row] <= wr_data;
         end
      end
   end

   assign rd_data = front_sel ? bank1[rd_row] : bank0[rd_row];

endmodule

// File: rtl/matrix_row_scanner.sv
// matrix_row_scanner
// Row scan controller for an 8x8 LED matrix feeding a 3-to-8 row decoder.
// Each row gets BLANK_CYCLES of blanking then DWELL_CYCLES of drive.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   en              : scan enable (level)
//   wr_en/wr_row/wr_data : back-buffer write port
//   commit          : request back/front swap at the next frame boundary
//   addr, nen       : decoder row index and active-low enable
//   col_data        : column pattern of the driven row (0 while blanking)
//   frame_done      : one-cycle pulse when row 7 drive ends
//   swap_pending    : commit latched, not yet applied
//
// state | meaning
// IDLE  | scan off, decoder disabled, pending commit applied at once
// BLANK | decoder disabled, addr holds upcoming row
// DRIVE | decoder enabled on addr, col_data = front[addr]
module matrix_row_scanner
   import matrix_scan_pkg::*;
#(
   parameter int DWELL_CYCLES = 1000,
   parameter int BLANK_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             wr_en,
   input  logic [ROW_W-1:0] wr_row,
   input  logic [COL_W-1:0] wr_data,
   input  logic             commit,
   output logic [ROW_W-1:0] addr,
   output logic             nen,
   output logic [COL_W-1:0] col_data,
   output logic             frame_done,
   output logic             swap_pending
);

   localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'(BLANK_CYCLES - 1);
   // Leaving IDLE spends one extra blank cycle: the edge that samples en
   // already shows blanking, and the first row still needs BLANK_CYCLES
   // more before the decoder is enabled.
   localparam logic [CNT_W-1:0] FIRST_LD = CNT_W'(BLANK_CYCLES);

   scan_state_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ROW_W-1:0] row_d;
   logic             frame_end;
   logic             swap;
   logic             pending_d;
   logic             nen_d;
   logic [COL_W-1:0] col_d;
   logic [COL_W-1:0] front_data;
   logic             tc;

   frame_dbuf u_dbuf (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_row  (wr_row),
      .wr_data (wr_data),
      .swap    (swap),
      .rd_row  (row_d),
      .rd_data (front_data)
   );

   assign tc = (cnt_q == '0);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      row_d     = addr;
      frame_end = 1'b0;
      case (state_q)
         IDLE: begin
            row_d = '0;
            if (en) begin
               state_d = BLANK;
               cnt_d   = FIRST_LD;
            end
         end
         BLANK: begin
            if (!en) begin
               state_d = IDLE;
               cnt_d   = '0;
               row_d   = '0;
            end else if (tc) begin
               state_d = DRIVE;
               cnt_d   = DWELL_LD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DRIVE: begin
            if (!en) begin
               state_d = IDLE;
               cnt_d   = '0;
               row_d   = '0;
            end else if (tc) begin
               state_d   = BLANK;
               cnt_d     = BLANK_LD;
               row_d     = addr + 1'b1;
               frame_end = (addr == ROW_W'(ROWS - 1));
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            row_d   = '0;
         end
      endcase
   end

   // A commit on the boundary edge itself is folded into that swap.
   always_comb begin
      swap      = ((state_q == IDLE) && swap_pending) ||
                  (frame_end && (swap_pending || commit));
      pending_d = swap ? ((state_q == IDLE) && commit) : (swap_pending || commit);
      nen_d     = (state_d != DRIVE);
      col_d     = nen_d ? '0 : front_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         addr         <= '0;
         nen          <= 1'b1;
         col_data     <= '0;
         frame_done   <= 1'b0;
         swap_pending <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         addr         <= row_d;
         nen          <= nen_d;
         col_data     <= col_d;
         frame_done   <= frame_end;
         swap_pending <= pending_d;
      end
   end

endmodule

// File: tb/tb_matrix_row_scanner.sv
// Self-checking bench for matrix_row_scanner (DWELL=3, BLANK=2).
module tb_matrix_row_scanner;
   import matrix_scan_pkg::*;

   localparam int D  = 3;
   localparam int B  = 2;
   localparam int P  = D + B;
   localparam int FP = 8 * P;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       wr_en = 1'b0;
   logic [2:0] wr_row = '0;
   logic [7:0] wr_data = '0;
   logic       commit = 1'b0;
   logic [2:0] addr;
   logic       nen;
   logic [7:0] col_data;
   logic       frame_done;
   logic       swap_pending;

   always #5 clk = ~clk;

   matrix_row_scanner #(.DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .wr_en        (wr_en),
      .wr_row       (wr_row),
      .wr_data      (wr_data),
      .commit       (commit),
      .addr         (addr),
      .nen          (nen),
      .col_data     (col_data),
      .frame_done   (frame_done),
      .swap_pending (swap_pending)
   );

   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   logic [13:0] sb_q [$];
   logic [13:0] last_exp;

   // reference model
   bit          m_run = 0;
   bit          m_pend = 0;
   bit          m_sel = 0;
   int          m_k = 0;
   logic [7:0]  m_buf [2][8];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // expected {addr,nen,col_data,frame_done,swap_pending} after this edge
   task automatic model(input bit e, input bit w, input logic [2:0] r,
                        input logic [7:0] d, input bit c, input bit rn);
      bit   run_before, fe, idle_sw, sw, n;
      int   row, j;
      logic [7:0]  col;
      logic [13:0] exp;
      run_before = m_run;
      if (!rn) begin
         m_run = 0; m_k = 0; m_pend = 0; m_sel = 0;
         for (int i = 0; i < 8; i++) begin
            m_buf[0][i] = '0;
            m_buf[1][i] = '0;
         end
         exp = {3'd0, 1'b1, 8'd0, 1'b0, 1'b0};
      end else begin
         fe = 0;
         if (m_run) begin
            if (!e) m_run = 0;
            else begin
               m_k++;
               if ((m_k - 1) > 0 && ((m_k - 1) % FP) == 0) fe = 1;
            end
         end else if (e) begin
            m_run = 1;
            m_k = 0;
         end
         idle_sw = !run_before && m_pend;
         sw = idle_sw || (fe && (m_pend || c));
         row = 0;
         n = 1;
         if (m_run && m_k > 0) begin
            j = m_k - 1;
            row = (j / P) % 8;
            n = (j % P) < B;
         end
         col = n ? 8'd0 : m_buf[m_sel][row];
         if (w) m_buf[!m_sel][r] = d;
         if (sw) m_sel = !m_sel;
         m_pend = sw ? (idle_sw && c) : (m_pend || c);
         exp = {row[2:0], n, col, fe, m_pend};
      end
      last_exp = exp;
      sb_q.push_back(exp);
   endtask

   task automatic step(input bit e, input bit w, input logic [2:0] r,
                       input logic [7:0] d, input bit c, input bit rn);
      logic [13:0] got;
      @(negedge clk);
      en = e; wr_en = w; wr_row = r; wr_data = d; commit = c; rst_n = rn;
      model(e, w, r, d, c, rn);
      @(posedge clk);
      #1;
      cyc++;
      got = {addr, nen, col_data, frame_done, swap_pending};
      chk($sformatf("cyc%0d", cyc), {18'd0, got}, {18'd0, sb_q.pop_front()});
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      // reset state
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      chk("rst_nen", {31'd0, nen}, 32'd1);

      // load rows with a walking one in IDLE, commit, let it apply
      for (int r = 0; r < 8; r++) step(0, 1, 3'(r), 8'h01 << r, 0, 1);
      step(0, 0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      chk("idle_commit_applied", {31'd0, swap_pending}, 32'd0);

      // two full frames
      run(2 * FP + 3);

      // mid-frame write + commit: visible only after the boundary
      step(1, 1, 3'd3, 8'hAA, 0, 1);
      step(1, 0, 0, 0, 1, 1);
      chk("pending_mid_frame", {31'd0, swap_pending}, 32'd1);
      run(2 * FP);

      // commit exactly on the frame_done edge
      step(1, 1, 3'd0, 8'h55, 0, 1);
      found = 0;
      for (int i = 0; i < 2 * FP && !found; i++) begin
         if (m_run && m_k > 0 && (m_k % FP) == 0) found = 1;
         else run(1);
      end
      chk("boundary_reached", {31'd0, found}, 32'd1);
      step(1, 0, 0, 0, 1, 1);
      chk("boundary_fd", {31'd0, frame_done}, 32'd1);
      chk("boundary_no_pending", {31'd0, swap_pending}, 32'd0);
      run(FP + 2);

      // drop en during drive of row 5
      found = 0;
      for (int i = 0; i < 2 * FP && !found; i++) begin
         if (last_exp[13:11] == 3'd5 && last_exp[10] == 1'b0) found = 1;
         else run(1);
      end
      chk("row5_reached", {31'd0, found}, 32'd1);
      step(0, 0, 0, 0, 0, 1);
      chk("drop_addr", {29'd0, addr}, 32'd0);
      step(0, 0, 0, 0, 0, 1);

      // restart, reset during drive
      run(B + 3);
      chk("drive_before_rst", {31'd0, nen}, 32'd0);
      step(1, 0, 0, 0, 0, 0);
      chk("rst_mid_col", {24'd0, col_data}, 32'd0);
      step(0, 0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 0, 1);
      run(FP + 3);
      step(0, 0, 0, 0, 0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/matrix_row_scanner.md
# matrix_row_scanner

Time-multiplexed row scan controller for an 8x8 LED matrix. It sits directly upstream of the 3-to-8 row decoder: it drives that decoder's `addr` and active-low `nen` inputs and presents the matching 8-bit column pattern. A double-buffered 8x8 frame store lets software-side logic build a new frame while the current one is displayed. The back buffer swaps in atomically at a frame boundary. Blanking between rows prevents ghosting.

## Interface

Clocking and reset:
- One clock, `clk`.
- `rst_n` is a synchronous, active-low reset, sampled on the rising edge of `clk`.

Parameters:
- `DWELL_CYCLES`, default 1000: cycles each row is driven (`nen`=0); legal range ≥1.
- `BLANK_CYCLES`, default 4: cycles of blanking (`nen`=1) before each row; legal range ≥1.

Ports:
- `clk` input 1: system clock.
- `rst_n` input 1: synchronous active-low reset.
- `en` input 1: scan enable (level).
- `wr_en` input 1: write strobe into the back buffer.
- `wr_row` input 3: back-buffer row index.
- `wr_data` input 8: column pattern for `wr_row`.
- `commit` input 1: one-cycle pulse requesting a back/front swap at the next frame boundary.
- `addr` output 3: row index to the decoder.
- `nen` output 1: active-low decoder enable.
- `col_data` output 8: column pattern for the row currently driven.
- `frame_done` output 1: one-cycle pulse at the end of row 7.
- `swap_pending` output 1: a commit is latched but not yet applied.

## Operation

- All outputs are registered.
- Reset values:
  - `addr`=0, `nen`=1, `col_data`=0, `frame_done`=0, `swap_pending`=0.
  - State is IDLE.
  - Both buffers are cleared to 0.
  - Front select is 0.
- IDLE:
  - `nen`=1, `col_data`=0, `addr`=0.
  - `en`=1 sampled → BLANK, with the counter loaded.
- BLANK:
  - `nen`=1, `col_data`=0; `addr` already holds the upcoming row.
  - After `BLANK_CYCLES` cycles → DRIVE.
- DRIVE:
  - `nen`=0 and `col_data`=front[`addr`].
  - After `DWELL_CYCLES` cycles → BLANK, and `addr` increments.
  - If `addr` was 7, it wraps to 0 and `frame_done` pulses.
- `en`=0 sampled in BLANK or DRIVE → IDLE on the next edge. This takes effect mid-row, with no completion of the row. `addr` returns to 0.
- Writes:
  - `wr_en`=1 writes `wr_data` to back[`wr_row`] on that edge.
  - Writes are accepted in every state, including IDLE.
- Commit:
  - `commit`=1 sets `swap_pending`.
  - The swap is applied on the same edge that raises `frame_done`, toggling front select and clearing `swap_pending`.
  - A `commit` coinciding with that edge is applied at that same boundary.
  - Multiple commits before a boundary collapse into one.
  - In IDLE, a pending commit is applied immediately on the next edge.
- A write in the swap cycle lands in the pre-swap back buffer, so it becomes visible in the next frame.
- The swap does not copy data. The new back buffer holds the frame before last.
- Reset mid-scan: all outputs return to their reset values on the next edge, regardless of state.

## Timing

- `en` sampled high at edge E:
  - `nen`=1 for edges E+1 … E+`BLANK_CYCLES`.
  - `nen`=0 from edge E+`BLANK_CYCLES`+1 for exactly `DWELL_CYCLES` cycles.
- `col_data` and `nen` change on the same edge. `addr` is stable throughout each BLANK+DRIVE pair.
- Row period is `BLANK_CYCLES`+`DWELL_CYCLES`. Frame period is 8×(`BLANK_CYCLES`+`DWELL_CYCLES`).
- `frame_done` rises on the edge where DRIVE of row 7 ends; it is high for one cycle, during the first BLANK cycle of row 0.
- Widths:
  - Counter is $clog2(max(`DWELL_CYCLES`,`BLANK_CYCLES`)+1) bits.
  - The counter reloads on every state change, and does not free-run.
  - `addr` increments modulo 8.

## Structure

- Package `matrix_scan_pkg` holds:
  - The state enum `scan_state_t` {IDLE, BLANK, DRIVE}.
  - `ROWS`=8, `ROW_W`=3, `COL_W`=8.
- Sub-module `frame_dbuf` holds the two 8×8 register banks, the front-select bit, the write port into the back bank, a combinational read port from the front bank, and a swap input.
- The top level holds the FSM, the counter, the address register and the commit latch.

## Test plan

- Reset then `en`=1 with `DWELL_CYCLES`=3 and `BLANK_CYCLES`=2 → `nen` pattern 1,1,0,0,0 per row; `addr` steps 0..7; `frame_done` pulses once every 40 cycles.
- Write rows 0..7 = 8'h01<<row, then `commit`, in IDLE; then `en`=1 → `col_data` equals 8'h01<<`addr` while `nen`=0, and 0 while blanking.
- Mid-frame `commit` after writing back[3]=8'hAA → front is unchanged until `frame_done`; the next frame shows 8'hAA on row 3; `swap_pending` is 1 until the boundary.
- `commit` on the exact `frame_done` edge → swap applied at that boundary; `swap_pending` never observed high.
- `en` dropped during DRIVE of row 5 → next cycle `nen`=1, `addr`=0, `col_data`=0.
- `rst_n`=0 during DRIVE → next cycle all outputs at their reset values and both buffers read 0 after a re-commit.
